// File: rtl/cmd_frame_pkg.sv
// rtl/cmd_frame_pkg.sv - shared FSM encoding and UART framing constants
package cmd_frame_pkg;
   localparam int DEFAULT_CLK_DIV = 434;
   localparam int DATA_BITS       = 8;
   localparam int STOP_BITS       = 1;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START_BIT  = 3'd1,
      ST_DATA_BIT   = 3'd2,
      ST_PARITY_BIT = 3'd3,
      ST_STOP_BIT   = 3'd4
   } tx_state_t;
endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with load/done handshake
// Optional even parity bit: define CMD_FRAME_TX_PARITY_EN.
module uart_tx_byte
   import cmd_frame_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       done,
   output logic       tx
);
   localparam int STOP_CYC = CLK_DIV * STOP_BITS;
   localparam int CNT_W    = $clog2(STOP_CYC);

   tx_state_t        state, state_nxt;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             tick;
`ifdef CMD_FRAME_TX_PARITY_EN
   logic             parity;
`endif

   // The stop period may span several bit times, every other state exactly one.
   assign tick = (state == ST_STOP_BIT) ? (baud_cnt == CNT_W'(STOP_CYC - 1))
                                        : (baud_cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
`ifdef CMD_FRAME_TX_PARITY_EN
         parity   <= 1'b0;
`endif
      end else if (load) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= data;
`ifdef CMD_FRAME_TX_PARITY_EN
         parity   <= ^data;
`endif
      end else if (state != ST_IDLE) begin
         baud_cnt <= tick ? '0 : baud_cnt + CNT_W'(1);
         if (tick && state == ST_DATA_BIT) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (load) state_nxt = ST_START_BIT;
         ST_START_BIT: if (tick) state_nxt = ST_DATA_BIT;
         ST_DATA_BIT:
            if (tick && bit_idx == 3'(DATA_BITS - 1))
`ifdef CMD_FRAME_TX_PARITY_EN
               state_nxt = ST_PARITY_BIT;
`else
               state_nxt = ST_STOP_BIT;
`endif
`ifdef CMD_FRAME_TX_PARITY_EN
         ST_PARITY_BIT: if (tick) state_nxt = ST_STOP_BIT;
`endif
         // A load on the final stop cycle chains the next byte with no idle gap.
         ST_STOP_BIT:  if (tick) state_nxt = load ? ST_START_BIT : ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      done = 1'b0;
      tx   = 1'b1;
      case (state)
         ST_START_BIT: tx = 1'b0;
         ST_DATA_BIT:  tx = shreg[0];
`ifdef CMD_FRAME_TX_PARITY_EN
         ST_PARITY_BIT: tx = parity;
`endif
         ST_STOP_BIT: begin
            tx   = 1'b1;
            done = tick;
         end
         default:      tx = 1'b1;
      endcase
   end
endmodule

// File: rtl/cmd_frame_tx.sv
// rtl/cmd_frame_tx.sv - command frame transmitter: cmd byte plus FIFO payload over UART
// Optional even parity bit per byte: define CMD_FRAME_TX_PARITY_EN.
module cmd_frame_tx
   import cmd_frame_pkg::*;
#(
   parameter  int CLK_DIV    = DEFAULT_CLK_DIV,
   parameter  int FIFO_DEPTH = 16,
   localparam int LEN_W      = $clog2(FIFO_DEPTH) + 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   output logic             full,
   input  logic             start,
   input  logic [7:0]       cmd,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             err,
   output logic             tx
);
   localparam int PTR_W = LEN_W - 1;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LEN_W-1:0] count, remaining;
   logic             accept, reject, pop, push_ok, load, done;
   logic [7:0]       load_data;

   assign full      = (count == LEN_W'(FIFO_DEPTH));
   assign accept    = start && !busy && (len <= count);
   assign reject    = start && !accept;
   assign pop       = done && (remaining != '0);
   // A pop in the same cycle frees a slot, so a push while full still lands.
   assign push_ok   = wr_en && (!full || pop);
   assign load      = accept || pop;
   assign load_data = accept ? cmd : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= reject || (wr_en && !push_ok);
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + LEN_W'(1);
            2'b01:   count <= count - LEN_W'(1);
            default: count <= count;
         endcase
         // len is latched at acceptance, so later writes never lengthen the frame.
         if (accept) begin
            busy      <= 1'b1;
            remaining <= len;
         end else if (pop) begin
            remaining <= remaining - LEN_W'(1);
         end else if (done) begin
            busy      <= 1'b0;
         end
      end
   end

   uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_uart (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .data (load_data),
      .done (done),
      .tx   (tx)
   );
endmodule

// File: tb/tb_cmd_frame_tx.sv
// tb/tb_cmd_frame_tx.sv - scoreboard bench for cmd_frame_tx (CLK_DIV=4, FIFO_DEPTH=4)
module tb_cmd_frame_tx;
`ifdef CMD_FRAME_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int STOP_S = 4 * (NB - 1) + 2;

   logic       clk, rst, wr_en, full, start, busy, err, tx;
   logic [7:0] wr_data, cmd;
   logic [2:0] len;

   int         checks = 0;
   int         failures = 0;
   int         err_cnt = 0;
   logic [7:0] exp_q[$];

   cmd_frame_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
      .start(start), .cmd(cmd), .len(len), .busy(busy), .err(err), .tx(tx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) if (err === 1'b1) err_cnt++;

   // Monitor: decodes tx mid-bit and compares each byte with the scoreboard head.
   int         m_cnt = 0;
   bit         m_active = 0;
   logic [7:0] m_byte = 8'h00;
`ifdef CMD_FRAME_TX_PARITY_EN
   logic       m_par = 1'b0;
`endif
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         m_active = 0;
      end else if (!m_active) begin
         if (tx === 1'b0) begin
            m_active = 1;
            m_cnt    = 0;
         end
      end else begin
         m_cnt++;
         if (m_cnt == 2) begin
            check("start_bit", {31'b0, tx}, 32'h0);
         end else if (m_cnt >= 6 && m_cnt <= 34 && (m_cnt - 6) % 4 == 0) begin
            m_byte = {tx, m_byte[7:1]};
`ifdef CMD_FRAME_TX_PARITY_EN
         end else if (m_cnt == 38) begin
            m_par = tx;
`endif
         end else if (m_cnt == STOP_S) begin
            logic [7:0] e;
            check("stop_bit", {31'b0, tx}, 32'h1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_byte actual=%0h required=none", m_byte);
            end else begin
               e = exp_q.pop_front();
               check("rx_byte", {24'b0, m_byte}, {24'b0, e});
`ifdef CMD_FRAME_TX_PARITY_EN
               check("parity_bit", {31'b0, m_par}, {31'b0, ^e});
`endif
            end
            m_active = 0;
         end
      end
   end

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = b;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Returns on the first cycle after the start is sampled.
   task automatic do_start(input logic [7:0] c, input logic [2:0] l);
      @(negedge clk);
      start = 1'b1;
      cmd = c;
      len = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int busy_n, output int low_n);
      busy_n = 0;
      low_n = 0;
      for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
         busy_n++;
         if (tx === 1'b0) low_n++;
         @(negedge clk);
      end
      if (busy !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL busy_timeout actual=%0b required=0", busy);
      end
   endtask

   task automatic expect_quiet(input string name);
      int bad = 0;
      repeat (10) begin
         if (busy !== 1'b0 || tx !== 1'b1) bad++;
         @(negedge clk);
      end
      check(name, bad, 0);
   endtask

   initial begin
      int bn, ln, e0;
      rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0; cmd = 8'h00; len = 3'd0;
      repeat (3) @(negedge clk);
      check("reset_tx", {31'b0, tx}, 32'h1);
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_err", {31'b0, err}, 32'h0);
      check("reset_full", {31'b0, full}, 32'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Three-byte frame, back-to-back
      push(8'h55);
      push(8'hA3);
      exp_q.push_back(8'h12); exp_q.push_back(8'h55); exp_q.push_back(8'hA3);
      do_start(8'h12, 3'd2);
      check("start_latency_tx", {31'b0, tx}, 32'h0);
      check("start_latency_busy", {31'b0, busy}, 32'h1);
      wait_idle(bn, ln);
      check("busy_cycles_3byte", bn, 3 * NB * 4);

      // Start with too few bytes is rejected
      e0 = err_cnt;
      do_start(8'h7E, 3'd1);
      check("reject_err_pulse", {31'b0, err}, 32'h1);
      expect_quiet("reject_quiet");
      check("reject_err_count", err_cnt - e0, 1);

      // Overfill a depth-4 FIFO, then write during the frame
      push(8'h01); push(8'h02); push(8'h03);
      check("not_full_at_3", {31'b0, full}, 32'h0);
      push(8'h04);
      check("full_at_4", {31'b0, full}, 32'h1);
      e0 = err_cnt;
      push(8'h05);
      @(negedge clk);
      check("drop_err_count", err_cnt - e0, 1);
      check("full_after_drop", {31'b0, full}, 32'h1);
      exp_q.push_back(8'hC4); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      exp_q.push_back(8'h03); exp_q.push_back(8'h04);
      do_start(8'hC4, 3'd4);
      repeat (60) @(negedge clk);
      push(8'h66);
      wait_idle(bn, ln);
      check("fifo_drained_not_full", {31'b0, full}, 32'h0);
      exp_q.push_back(8'h33); exp_q.push_back(8'h66);
      do_start(8'h33, 3'd1);
      wait_idle(bn, ln);
      check("busy_cycles_2byte", bn, 2 * NB * 4);

      // len = 0: command byte only
      exp_q.push_back(8'h00);
      do_start(8'h00, 3'd0);
      wait_idle(bn, ln);
      check("busy_cycles_len0", bn, NB * 4);
      check("tx_low_cycles_len0", ln, 4 * (NB - 1));

      // Odd and even parity commands
      exp_q.push_back(8'h07);
      do_start(8'h07, 3'd0);
      wait_idle(bn, ln);
      exp_q.push_back(8'h03);
      do_start(8'h03, 3'd0);
      wait_idle(bn, ln);
      repeat (4) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      // Reset during DATA_BIT3 of a three-byte frame
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      check("full_before_reset", {31'b0, full}, 32'h1);
      exp_q.push_back(8'h5A); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      do_start(8'h5A, 3'd2);
      repeat (17) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_tx", {31'b0, tx}, 32'h1);
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_full", {31'b0, full}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      e0 = err_cnt;
      do_start(8'h01, 3'd1);
      check("post_reset_reject_err", {31'b0, err}, 32'h1);
      expect_quiet("post_reset_quiet");
      check("post_reset_err_count", err_cnt - e0, 1);
      check("final_scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cmd_frame_tx.md
CMD_FRAME_TX -- requirements
Module: cmd_frame_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 434, meaning clock cycles per UART bit (minimum 2).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, meaning payload FIFO depth in bytes (power of two, minimum 2).
REQ-003 The block SHALL have derived localparam LEN_W = clog2(FIFO_DEPTH)+1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port wr_en, input, 1 bit: push wr_data into the payload FIFO.
REQ-007 The block SHALL have port wr_data, input, 8 bits: payload byte.
REQ-008 The block SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH bytes.
REQ-009 The block SHALL have port start, input, 1 bit: single-cycle frame request.
REQ-010 The block SHALL have port cmd, input, 8 bits: command byte, sampled with start.
REQ-011 The block SHALL have port len, input, LEN_W bits: payload byte count, sampled with start.
REQ-012 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse on a rejected start or a dropped write.
REQ-014 The block SHALL have port tx, output, 1 bit: UART serial line, idle high.

Function
REQ-015 The block SHALL transmit each frame as the cmd byte followed by len bytes popped from the FIFO in write order; each byte is 8N1, LSB first, and each bit is exactly CLK_DIV cycles.
REQ-016 The FSM SHALL have the states IDLE, START_BIT, DATA_BIT(0..7), PARITY_BIT (PARITY_EN only) and STOP_BIT.
REQ-017 In IDLE, a start with len <= FIFO count SHALL be accepted; busy rises and tx drives the start bit (0) on the next cycle, a latency of 1.
REQ-018 A start with len > FIFO count, or any start while busy, SHALL be ignored, and err SHALL pulse on the following cycle.
REQ-019 len = 0 SHALL send the cmd byte only.
REQ-020 When STOP_BIT ends and bytes remain, the next START_BIT SHALL begin on the next cycle with no idle gap; the byte pop SHALL occur on the cycle the start bit begins.
REQ-021 busy SHALL fall on the cycle after the last STOP_BIT completes; a start in that same cycle is accepted.
REQ-022 A wr_en while full SHALL drop the byte, pulse err, and leave the FIFO unchanged.
REQ-023 A simultaneous push and pop SHALL both take effect, leaving the count unchanged; a push while full and popping SHALL be accepted.
REQ-024 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL span 0..FIFO_DEPTH inclusive.
REQ-025 Writes during a frame SHALL be allowed but SHALL NOT extend the current frame.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL force tx=1, busy=0, err=0, full=0, FIFO empty, FSM=IDLE, and bit counter=0.
REQ-027 A reset mid-frame SHALL abort the frame immediately (tx high on the next edge) and discard all FIFO contents.

Configuration
REQ-028 When the macro CMD_FRAME_TX_PARITY_EN is defined, an even-parity bit over the 8 data bits SHALL be inserted between DATA_BIT7 and STOP_BIT, for an 11-bit frame.
REQ-029 When CMD_FRAME_TX_PARITY_EN is not defined, PARITY_BIT logic SHALL be absent and frames SHALL be 10 bits.

Structure
REQ-030 The shared package cmd_frame_pkg SHALL hold the FSM state encoding, the UART bit-count constants (data bits 8, stop bits 1), and the default CLK_DIV.
REQ-031 A sub-module uart_tx_byte SHALL own the baud counter, the shift register and tx, with a load/done handshake; cmd_frame_tx SHALL own the FIFO, the frame sequencing, and busy/err.

Verification (bench uses CLK_DIV=4, FIFO_DEPTH=4)
REQ-032 Push 0x55 and 0xA3, then start cmd=0x12 len=2 -> tx carries bytes 0x12, 0x55, 0xA3 back-to-back; busy is high for 120 cycles (132 with parity) and falls 1 cycle after.
REQ-033 With an empty FIFO, start cmd=0x7E len=1 -> err pulses once, busy stays 0, tx stays 1.
REQ-034 Push 5 bytes into a depth-4 FIFO -> full after the 4th push, err on the 5th, and the later frame sends the first 4 bytes only.
REQ-035 start len=0 cmd=0x00 -> exactly 40 cycles of busy; tx is low for 36 cycles (start bit plus 8 zero data bits), then high for the stop bit.
REQ-036 With PARITY_EN defined, send cmd=0x07 -> the parity bit is 1; send cmd=0x03 -> the parity bit is 0.
REQ-037 Assert rst=0 during DATA_BIT3 of a 3-byte frame -> tx=1, busy=0 and full=0 on the next edge; a subsequent start with len=1 is rejected with err.
